pool_sched: RTL and testbench

Channel scheduler for the `maxpool2x2` engine. It accepts a start command with feature-map geometry, then streams `cfg_channels` planes of `cfg_in_width` × `cfg_in_height` pixels from an upstream valid/ready source through the single engine, one plane at a time. Between planes it clears the engine. It counts the engine's results, tags each one with its channel and a last-of-plane flag, and reports done or a configuration error. It sits between the line-buffer DMA and the engine in the pooling layer.

---
 rtl/pool_pkg.sv | 19 +
 rtl/pool_cnt2d.sv | 46 ++++
 rtl/pool_sched.sv | 146 ++++++++++++++
 tb/tb_pool_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and helpers for the maxpool channel scheduler.
package pool_pkg;

    localparam int MAXW = 256;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } pool_state_e;

    // A plane dimension is legal when it is even, at least 2 and within maxv.
    function automatic logic dim_ok(input logic [15:0] v, input logic [16:0] maxv);
        return (v[0] == 1'b0) && (v >= 16'd2) && ({1'b0, v} <= maxv);
    endfunction

endpackage

// File: rtl/pool_cnt2d.sv
// Column/row position counter over a width x height plane; last_o flags the final pixel.
module pool_cnt2d (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        inc_i,
    input  logic [15:0] width_i,
    input  logic [15:0] height_i,
    output logic        last_o
);

    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;
    logic        col_end, row_end;

    assign col_end = (col_q == width_i - 16'd1);
    assign row_end = (row_q == height_i - 16'd1);
    assign last_o  = col_end && row_end;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (inc_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? 16'd0 : row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/pool_sched.sv
// Channel scheduler: streams nch planes through one maxpool2x2 engine, clearing it
// between planes and tagging each pooled result with its channel and last-of-plane.
module pool_sched
    import pool_pkg::*;
#(
    parameter int DATAW = 8,
    parameter int MAXW  = pool_pkg::MAXW,
    parameter int CHW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      cfg_in_width,
    input  logic [15:0]      cfg_in_height,
    input  logic [CHW-1:0]   cfg_channels,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             s_valid,
    input  logic [DATAW-1:0] s_data,
    output logic             s_ready,
    output logic             pool_rst_b,
    output logic             pool_in_vld,
    output logic [DATAW-1:0] pool_in_data,
    output logic [15:0]      pool_cfg_out_width,
    input  logic             pool_out_vld,
    input  logic [DATAW-1:0] pool_out_data,
    output logic             m_valid,
    output logic [DATAW-1:0] m_data,
    output logic [CHW-1:0]   m_ch,
    output logic             m_last,
    output logic [2:0]       dbg_state
);

    pool_state_e    state_q;
    logic [15:0]    w_q, h_q;
    logic [CHW-1:0] nch_q, ch_q;
    logic [23:0]    total_q, out_cnt_q;
    logic           pool_rst_b_q, done_q, err_q;

    logic           active, px_fire, px_last, count_en, plane_done, cfg_ok;
    logic [23:0]    plane_total, last_idx;

    // Upstream handshake: a pixel moves when s_valid && s_ready on a rising edge;
    // s_ready depends only on state, never on s_valid, and there is no skid storage.
    assign active   = (state_q == S_CLR) || (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign s_ready  = (state_q == S_STREAM);
    assign px_fire  = s_valid && s_ready;
    assign count_en = pool_out_vld && active;
    assign last_idx = total_q - 24'd1;

    assign cfg_ok      = dim_ok(cfg_in_width, 17'(MAXW)) && dim_ok(cfg_in_height, 17'h1FFFF)
                         && (cfg_channels != '0);
    assign plane_total = 24'(cfg_in_width[15:1]) * 24'(cfg_in_height[15:1]);
    // The final result of a plane may be counted in the same cycle it arrives.
    assign plane_done  = (out_cnt_q == total_q) || (count_en && (out_cnt_q == last_idx));

    pool_cnt2d u_px_cnt (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (state_q == S_CLR),
        .inc_i    (px_fire),
        .width_i  (w_q),
        .height_i (h_q),
        .last_o   (px_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            w_q          <= '0;
            h_q          <= '0;
            nch_q        <= '0;
            ch_q         <= '0;
            total_q      <= '0;
            out_cnt_q    <= '0;
            pool_rst_b_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (count_en) out_cnt_q <= out_cnt_q + 24'd1;
            case (state_q)
                S_IDLE: begin
                    pool_rst_b_q <= 1'b1;
                    if (start) begin
                        w_q     <= cfg_in_width;
                        h_q     <= cfg_in_height;
                        nch_q   <= cfg_channels;
                        total_q <= plane_total;
                        if (cfg_ok) begin
                            ch_q         <= '0;
                            pool_rst_b_q <= 1'b0;
                            state_q      <= S_CLR;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    pool_rst_b_q <= 1'b1;
                    out_cnt_q    <= '0;
                    state_q      <= S_STREAM;
                end
                S_STREAM: begin
                    if (px_fire && px_last) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (plane_done) begin
                        if (ch_q == nch_q - CHW'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            ch_q         <= ch_q + CHW'(1);
                            pool_rst_b_q <= 1'b0;
                            state_q      <= S_CLR;
                        end
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            if (abort && active) begin
                state_q      <= S_IDLE;
                pool_rst_b_q <= 1'b0;
                done_q       <= 1'b0;
            end
        end
    end

    assign busy               = (state_q != S_IDLE);
    assign done               = done_q;
    assign err                = err_q;
    assign pool_rst_b         = pool_rst_b_q;
    assign pool_in_vld        = px_fire;
    assign pool_in_data       = px_fire ? s_data : '0;
    assign pool_cfg_out_width = {1'b0, w_q[15:1]};
    assign m_valid            = count_en;
    assign m_data             = count_en ? pool_out_data : '0;
    assign m_ch               = ch_q;
    assign m_last             = count_en && (out_cnt_q == last_idx);
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_pool_sched.sv
// Directed bench for pool_sched with a behavioural stand-in for the maxpool2x2 engine.
module tb_pool_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] cfg_in_width = '0, cfg_in_height = '0;
    logic [7:0]  cfg_channels = '0;
    logic        busy, done, err;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        pool_rst_b, pool_in_vld;
    logic [7:0]  pool_in_data;
    logic [15:0] pool_cfg_out_width;
    logic        pool_out_vld;
    logic [7:0]  pool_out_data;
    logic        m_valid;
    logic [7:0]  m_data, m_ch;
    logic        m_last;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pool_sched dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_in_width(cfg_in_width), .cfg_in_height(cfg_in_height), .cfg_channels(cfg_channels),
        .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .pool_rst_b(pool_rst_b), .pool_in_vld(pool_in_vld), .pool_in_data(pool_in_data),
        .pool_cfg_out_width(pool_cfg_out_width),
        .pool_out_vld(pool_out_vld), .pool_out_data(pool_out_data),
        .m_valid(m_valid), .m_data(m_data), .m_ch(m_ch), .m_last(m_last),
        .dbg_state(dbg_state)
    );

    // Engine stand-in: emits the bottom-right pixel of each 2x2 block one cycle later.
    int   e_col = 0;
    logic e_row = 1'b0;
    logic e_vld = 1'b0;
    logic [7:0] e_data = '0;
    assign pool_out_vld  = e_vld;
    assign pool_out_data = e_data;

    always @(posedge clk) begin
        if (!pool_rst_b) begin
            e_col <= 0;
            e_row <= 1'b0;
            e_vld <= 1'b0;
        end else begin
            e_vld <= 1'b0;
            if (pool_in_vld) begin
                if (e_col[0] && e_row) begin
                    e_vld  <= 1'b1;
                    e_data <= pool_in_data;
                end
                if (e_col == 2 * int'(pool_cfg_out_width) - 1) begin
                    e_col <= 0;
                    e_row <= ~e_row;
                end else begin
                    e_col <= e_col + 1;
                end
            end
        end
    end

    // Monitor: collects pooled results and event counts.
    int   hs_cnt = 0, res_n = 0, rst_pulses = 0, rst_low = 0;
    int   done_cnt = 0, err_cnt = 0, done_busy_bad = 0, bad_ready = 0;
    logic prev_done = 1'b0, prev_rst_b = 1'b0;
    logic [7:0] res_data [512];
    logic [7:0] res_ch [512];
    logic       res_last [512];

    always @(negedge clk) begin
        if (s_valid && s_ready) hs_cnt++;
        if (m_valid && res_n < 512) begin
            res_data[res_n] = m_data;
            res_ch[res_n]   = m_ch;
            res_last[res_n] = m_last;
            res_n++;
        end
        if (!pool_rst_b && prev_rst_b) rst_pulses++;
        if (!pool_rst_b) rst_low++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if ((done && !busy) || (prev_done && !done && busy)) done_busy_bad++;
        if (!pool_rst_b && s_ready) bad_ready++;
        prev_done  = done;
        prev_rst_b = pool_rst_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int w, input int h, input int n);
        cfg_in_width  = 16'(w);
        cfg_in_height = 16'(h);
        cfg_channels  = 8'(n);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input int n, input int base, input bit gap);
        int guard;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(base + i);
            guard   = 0;
            @(negedge clk);
            while (!s_ready && guard < 64) begin
                step();
                @(negedge clk);
                guard++;
            end
            if (!s_ready) check("send_ready_timeout", 32'(s_ready), 1);
            step();
            if (gap && i != n - 1) begin
                s_valid = 1'b0;
                step();
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            step();
        end
        check(tag, 32'(got), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_hs, b_res, b_pul, b_low, b_done, b_err, b_bad, b_rdy, nl;
        logic [7:0] exp2 [8];
        exp2 = '{8'd5, 8'd7, 8'd13, 8'd15, 8'd21, 8'd23, 8'd29, 8'd31};

        // Reset values
        repeat (3) step();
        @(negedge clk);
        check("rst_state", 32'(dbg_state), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_pool_rst_b", 32'(pool_rst_b), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_cfg_w", 32'(pool_cfg_out_width), 0);
        check("rst_m_ch", 32'(m_ch), 0);
        rst = 1'b0;
        step();
        step();
        @(negedge clk);
        check("idle_pool_rst_b", 32'(pool_rst_b), 1);
        step();

        // Single plane 4x2
        b_hs = hs_cnt; b_res = res_n; b_done = done_cnt; b_bad = done_busy_bad; b_low = rst_low;
        start_job(4, 2, 1);
        @(negedge clk);
        check("t1_clr_state", 32'(dbg_state), 1);
        check("t1_clr_rst_b", 32'(pool_rst_b), 0);
        check("t1_clr_busy", 32'(busy), 1);
        check("t1_clr_ready", 32'(s_ready), 0);
        check("t1_cfg_w", 32'(pool_cfg_out_width), 2);
        step();
        @(negedge clk);
        check("t1_first_ready", 32'(s_ready), 1);
        step();
        send(8, 0, 1'b0);
        @(negedge clk);
        check("t1_drain_state", 32'(dbg_state), 3);
        check("t1_last_valid", 32'(m_valid), 1);
        check("t1_last_flag", 32'(m_last), 1);
        check("t1_last_data", 32'(m_data), 7);
        step();
        @(negedge clk);
        check("t1_done", 32'(done), 1);
        check("t1_done_busy", 32'(busy), 1);
        step();
        @(negedge clk);
        check("t1_done_fall", 32'(done), 0);
        check("t1_busy_fall", 32'(busy), 0);
        step();
        check("t1_hs", 32'(hs_cnt - b_hs), 8);
        check("t1_nres", 32'(res_n - b_res), 2);
        check("t1_d0", 32'(res_data[b_res]), 5);
        check("t1_l0", 32'(res_last[b_res]), 0);
        check("t1_ch1", 32'(res_ch[b_res + 1]), 0);
        check("t1_ndone", 32'(done_cnt - b_done), 1);
        check("t1_done_busy_align", 32'(done_busy_bad - b_bad), 0);
        check("t1_rst_low", 32'(rst_low - b_low), 1);

        // Two planes 4x4 with s_valid gaps
        b_hs = hs_cnt; b_res = res_n; b_done = done_cnt; b_pul = rst_pulses; b_rdy = bad_ready;
        start_job(4, 4, 2);
        step();
        send(16, 0, 1'b1);
        @(negedge clk);
        check("t2_drain_state", 32'(dbg_state), 3);
        check("t2_drain_ready", 32'(s_ready), 0);
        check("t2_p0_last", 32'(m_last), 1);
        check("t2_p0_data", 32'(m_data), 15);
        step();
        @(negedge clk);
        check("t2_bubble_state", 32'(dbg_state), 1);
        check("t2_bubble_rst_b", 32'(pool_rst_b), 0);
        check("t2_bubble_ready", 32'(s_ready), 0);
        check("t2_bubble_ch", 32'(m_ch), 1);
        step();
        @(negedge clk);
        check("t2_p1_ready", 32'(s_ready), 1);
        check("t2_p1_rst_b", 32'(pool_rst_b), 1);
        step();
        send(16, 16, 1'b1);
        @(negedge clk);
        check("t2_p1_last", 32'(m_last), 1);
        check("t2_p1_ch", 32'(m_ch), 1);
        step();
        @(negedge clk);
        check("t2_done", 32'(done), 1);
        step();
        step();
        check("t2_nres", 32'(res_n - b_res), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_data%0d", i), 32'(res_data[b_res + i]), 32'(exp2[i]));
            check($sformatf("t2_ch%0d", i), 32'(res_ch[b_res + i]), (i < 4) ? 0 : 1);
            check($sformatf("t2_last%0d", i), 32'(res_last[b_res + i]), (i == 3 || i == 7) ? 1 : 0);
        end
        check("t2_hs", 32'(hs_cnt - b_hs), 32);
        check("t2_rst_pulses", 32'(rst_pulses - b_pul), 2);
        check("t2_ready_in_clr", 32'(bad_ready - b_rdy), 0);
        check("t2_ndone", 32'(done_cnt - b_done), 1);

        // Illegal configurations
        b_pul = rst_pulses; b_err = err_cnt; b_done = done_cnt;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: start_job(5, 2, 1);
                1: start_job(4, 0, 1);
                2: start_job(258, 2, 1);
                default: start_job(4, 2, 0);
            endcase
            @(negedge clk);
            check($sformatf("t3_err%0d", i), 32'(err), 1);
            check($sformatf("t3_busy%0d", i), 32'(busy), 0);
            check($sformatf("t3_ready%0d", i), 32'(s_ready), 0);
            check($sformatf("t3_rst_b%0d", i), 32'(pool_rst_b), 1);
            check($sformatf("t3_state%0d", i), 32'(dbg_state), 0);
            step();
            @(negedge clk);
            check($sformatf("t3_err_fall%0d", i), 32'(err), 0);
            step();
        end
        check("t3_no_rst_pulse", 32'(rst_pulses - b_pul), 0);
        check("t3_nerr", 32'(err_cnt - b_err), 4);
        check("t3_no_done", 32'(done_cnt - b_done), 0);

        // Abort after 10 pixels of plane 1
        start_job(8, 4, 3);
        step();
        b_pul = rst_pulses; b_done = done_cnt;
        send(10, 0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        check("t4_pre_state", 32'(dbg_state), 2);
        check("t4_res_valid", 32'(m_valid), 1);
        check("t4_res_data", 32'(m_data), 9);
        step();
        abort = 1'b0;
        @(negedge clk);
        check("t4_idle", 32'(dbg_state), 0);
        check("t4_rst_b_low", 32'(pool_rst_b), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_ready", 32'(s_ready), 0);
        step();
        @(negedge clk);
        check("t4_rst_b_high", 32'(pool_rst_b), 1);
        step();
        step();
        check("t4_one_pulse", 32'(rst_pulses - b_pul), 1);
        check("t4_no_done", 32'(done_cnt - b_done), 0);
        b_res = res_n;
        start_job(4, 2, 1);
        step();
        send(8, 100, 1'b0);
        wait_done("t4_restart_done", 10);
        check("t4_restart_nres", 32'(res_n - b_res), 2);
        check("t4_restart_d0", 32'(res_data[b_res]), 105);
        check("t4_restart_d1", 32'(res_data[b_res + 1]), 107);

        // Reset during DRAIN
        start_job(4, 2, 1);
        step();
        send(8, 0, 1'b0);
        @(negedge clk);
        check("t5_in_drain", 32'(dbg_state), 3);
        rst = 1'b1;
        step();
        @(negedge clk);
        check("t5_state", 32'(dbg_state), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_rst_b", 32'(pool_rst_b), 0);
        check("t5_m_valid", 32'(m_valid), 0);
        check("t5_ready", 32'(s_ready), 0);
        check("t5_done", 32'(done), 0);
        check("t5_cfg_w", 32'(pool_cfg_out_width), 0);
        rst = 1'b0;
        step();
        step();

        // Maximum width 256x2
        b_res = res_n;
        start_job(256, 2, 1);
        @(negedge clk);
        check("t6_cfg_w", 32'(pool_cfg_out_width), 128);
        step();
        send(512, 0, 1'b0);
        wait_done("t6_done", 10);
        check("t6_nres", 32'(res_n - b_res), 128);
        check("t6_d0", 32'(res_data[b_res]), 1);
        check("t6_d127", 32'(res_data[b_res + 127]), 255);
        check("t6_last127", 32'(res_last[b_res + 127]), 1);
        nl = 0;
        for (int i = 0; i < 128; i++) nl += int'(res_last[b_res + i]);
        check("t6_nlast", 32'(nl), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
